regfile_wb_arbiter: RTL and testbench



---
 rtl/regfile_pkg.sv | 18 +
 rtl/wb_fifo.sv | 76 +++++++
 rtl/regfile_wb_arbiter.sv | 125 ++++++++++++
 tb/tb_regfile_wb_arbiter.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared definitions for the register-file writeback path: default widths,
// requester indices and the writeback request record.
package regfile_pkg;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NREGS = 2 ** AW;

    // Requester indices, also the encoding used by the arbiter's last_grant.
    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_LSU = 1'b1;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Per-requester writeback FIFO. Requests to x0 are accepted and dropped so
// they never reach the write port. Per-entry valid bits and addresses are
// exported so the top level can build the pending-write mask.
module wb_fifo #(
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [AW-1:0]              in_addr,
    input  logic [DW-1:0]              in_data,
    input  logic                       pop,
    output logic                       head_valid,
    output logic [AW-1:0]              head_addr,
    output logic [DW-1:0]              head_data,
    output logic [DEPTH-1:0]           entry_valid,
    output logic [DEPTH-1:0][AW-1:0]   entry_addr
);

    localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

    logic [PW-1:0]             wr_ptr_r;
    logic [PW-1:0]             rd_ptr_r;
    logic [PW:0]               count_r;
    logic [DEPTH-1:0]          valid_r;
    logic [DEPTH-1:0][AW-1:0]  addr_r;
    logic [DEPTH-1:0][DW-1:0]  data_r;
    logic                      store_s;
    logic                      pop_s;

    // Handshake and head decode; ready depends on stored count only.
    always_comb begin
        in_ready   = (count_r < DEPTH_C);
        store_s    = in_valid && in_ready && (in_addr != {AW{1'b0}});
        pop_s      = pop && valid_r[rd_ptr_r];
        head_valid = valid_r[rd_ptr_r];
        head_addr  = addr_r[rd_ptr_r];
        head_data  = data_r[rd_ptr_r];
    end

    assign entry_valid = valid_r;
    assign entry_addr  = addr_r;

    // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {(PW + 1){1'b0}};
            valid_r  <= {DEPTH{1'b0}};
            addr_r   <= {(DEPTH * AW){1'b0}};
            data_r   <= {(DEPTH * DW){1'b0}};
        end else begin
            if (store_s) begin
                addr_r[wr_ptr_r]  <= in_addr;
                data_r[wr_ptr_r]  <= in_data;
                valid_r[wr_ptr_r] <= 1'b1;
                wr_ptr_r          <= wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                valid_r[rd_ptr_r] <= 1'b0;
                rd_ptr_r          <= rd_ptr_r + PW'(1);
            end
            case ({store_s, pop_s})
                2'b10:   count_r <= count_r + (PW + 1)'(1);
                2'b01:   count_r <= count_r - (PW + 1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-port scheduler for the three-port register file. Two writeback
// requesters (ALU, LSU) each feed a small FIFO; a round-robin arbiter drains
// one head per cycle into the registered a3/we3/wd3 write port. The pending
// mask flags every register with a queued or in-flight write.
module regfile_wb_arbiter #(
    parameter int DW    = regfile_pkg::DW,
    parameter int AW    = regfile_pkg::AW,
    parameter int DEPTH = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                alu_valid,
    output logic                alu_ready,
    input  logic [AW-1:0]       alu_addr,
    input  logic [DW-1:0]       alu_data,
    input  logic                lsu_valid,
    output logic                lsu_ready,
    input  logic [AW-1:0]       lsu_addr,
    input  logic [DW-1:0]       lsu_data,
    output logic [AW-1:0]       a3,
    output logic                we3,
    output logic [DW-1:0]       wd3,
    output logic [(2**AW)-1:0]  pending
);

    import regfile_pkg::*;

    localparam int NREG_C = 2 ** AW;

    logic                      alu_hv_s;
    logic [AW-1:0]             alu_ha_s;
    logic [DW-1:0]             alu_hd_s;
    logic [DEPTH-1:0]          alu_ev_s;
    logic [DEPTH-1:0][AW-1:0]  alu_ea_s;
    logic                      lsu_hv_s;
    logic [AW-1:0]             lsu_ha_s;
    logic [DW-1:0]             lsu_hd_s;
    logic [DEPTH-1:0]          lsu_ev_s;
    logic [DEPTH-1:0][AW-1:0]  lsu_ea_s;
    logic                      grant_alu_s;
    logic                      grant_lsu_s;
    logic                      last_grant_r;
    logic [AW-1:0]             a3_r;
    logic                      we3_r;
    logic [DW-1:0]             wd3_r;
    logic [NREG_C-1:0]         pending_s;

    wb_fifo #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_alu_fifo (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (alu_valid),
        .in_ready    (alu_ready),
        .in_addr     (alu_addr),
        .in_data     (alu_data),
        .pop         (grant_alu_s),
        .head_valid  (alu_hv_s),
        .head_addr   (alu_ha_s),
        .head_data   (alu_hd_s),
        .entry_valid (alu_ev_s),
        .entry_addr  (alu_ea_s)
    );

    wb_fifo #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) u_lsu_fifo (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (lsu_valid),
        .in_ready    (lsu_ready),
        .in_addr     (lsu_addr),
        .in_data     (lsu_data),
        .pop         (grant_lsu_s),
        .head_valid  (lsu_hv_s),
        .head_addr   (lsu_ha_s),
        .head_data   (lsu_hd_s),
        .entry_valid (lsu_ev_s),
        .entry_addr  (lsu_ea_s)
    );

    // Round-robin grant: a lone head wins; on a tie the requester not served last wins.
    always_comb begin
        grant_alu_s = alu_hv_s && (!lsu_hv_s || (last_grant_r == REQ_LSU));
        grant_lsu_s = lsu_hv_s && !grant_alu_s;
    end

    // Output register and grant history; a3/wd3 hold their value on idle cycles.
    always_ff @(posedge clk) begin
        if (reset) begin
            we3_r        <= 1'b0;
            a3_r         <= {AW{1'b0}};
            wd3_r        <= {DW{1'b0}};
            last_grant_r <= REQ_LSU;
        end else if (grant_alu_s) begin
            we3_r        <= 1'b1;
            a3_r         <= alu_ha_s;
            wd3_r        <= alu_hd_s;
            last_grant_r <= REQ_ALU;
        end else if (grant_lsu_s) begin
            we3_r        <= 1'b1;
            a3_r         <= lsu_ha_s;
            wd3_r        <= lsu_hd_s;
            last_grant_r <= REQ_LSU;
        end else begin
            we3_r        <= 1'b0;
            a3_r         <= a3_r;
            wd3_r        <= wd3_r;
            last_grant_r <= last_grant_r;
        end
    end

    // Pending mask: every queued entry plus the write currently on the port; x0 never pends.
    always_comb begin
        pending_s = {NREG_C{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            pending_s[alu_ea_s[i]] = pending_s[alu_ea_s[i]] | alu_ev_s[i];
            pending_s[lsu_ea_s[i]] = pending_s[lsu_ea_s[i]] | lsu_ev_s[i];
        end
        pending_s[a3_r] = pending_s[a3_r] | we3_r;
        pending_s[0]    = 1'b0;
    end

    assign a3      = a3_r;
    assign we3     = we3_r;
    assign wd3     = wd3_r;
    assign pending = pending_s;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: directed stimulus pushes the
// hand-predicted write sequence; a monitor pops and compares on every we3.
module tb_regfile_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid, alu_ready, lsu_valid, lsu_ready;
    logic [4:0]  alu_addr, lsu_addr, a3;
    logic [31:0] alu_data, lsu_data, wd3, pending;
    logic        we3;

    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   fails  = 0;

    regfile_wb_arbiter #(.DW(32), .AW(5), .DEPTH(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .alu_valid (alu_valid),
        .alu_ready (alu_ready),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_addr  (lsu_addr),
        .lsu_data  (lsu_data),
        .a3        (a3),
        .we3       (we3),
        .wd3       (wd3),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic pulse_reset;
        alu_valid = 1'b0;
        lsu_valid = 1'b0;
        reset     = 1'b1;
        tick();
        reset     = 1'b0;
    endtask

    // Monitor: every write on the port must match the next predicted write.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (we3 === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_write: got a3=%0d wd3=0x%0h expected no write at %0t", a3, wd3, $time);
                end else begin
                    e = q.pop_front();
                    chk("wb_addr", 64'(a3), 64'(e.a));
                    chk("wb_data", 64'(wd3), 64'(e.d));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int ai, li, cyc;
        logic ar, lr, seen_alu_full, seen_lsu_full;
        reset = 1'b1; alu_valid = 1'b0; lsu_valid = 1'b0;
        alu_addr = 5'd0; lsu_addr = 5'd0; alu_data = 32'd0; lsu_data = 32'd0;
        @(negedge clk);
        tick();
        // reset state
        chk("rst_we3", 64'(we3), 64'd0);
        chk("rst_a3", 64'(a3), 64'd0);
        chk("rst_wd3", 64'(wd3), 64'd0);
        chk("rst_pending", 64'(pending), 64'd0);
        chk("rst_alu_ready", 64'(alu_ready), 64'd1);
        chk("rst_lsu_ready", 64'(lsu_ready), 64'd1);
        reset = 1'b0;

        // single ALU write: latency and pending window
        alu_valid = 1'b1; alu_addr = 5'd4; alu_data = 32'd5;
        q.push_back('{a: 5'd4, d: 32'd5});
        tick();                                    // edge 1
        alu_valid = 1'b0;
        chk("t1_pend_e1", 64'(pending[4]), 64'd1);
        chk("t1_we3_e1", 64'(we3), 64'd0);
        tick();                                    // edge 2
        chk("t1_we3_e2", 64'(we3), 64'd1);
        chk("t1_pend_e2", 64'(pending[4]), 64'd1);
        tick();                                    // edge 3
        chk("t1_pend_e3", 64'(pending[4]), 64'd0);
        chk("t1_we3_e3", 64'(we3), 64'd0);

        // simultaneous requests after reset: ALU first, then LSU
        pulse_reset();
        alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'hAA;
        lsu_valid = 1'b1; lsu_addr = 5'd7; lsu_data = 32'hBB;
        q.push_back('{a: 5'd3, d: 32'hAA});
        q.push_back('{a: 5'd7, d: 32'hBB});
        tick();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        chk("t2_pending", 64'(pending), 64'h88);
        tick();
        chk("t2_first_a3", 64'(a3), 64'd3);
        tick();
        chk("t2_second_a3", 64'(a3), 64'd7);
        // last_grant now LSU: the next tie goes to the ALU
        alu_valid = 1'b1; alu_addr = 5'd9;  alu_data = 32'h11;
        lsu_valid = 1'b1; lsu_addr = 5'd10; lsu_data = 32'h22;
        q.push_back('{a: 5'd9,  d: 32'h11});
        q.push_back('{a: 5'd10, d: 32'h22});
        tick();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        repeat (3) tick();
        chk("t2_idle_we3", 64'(we3), 64'd0);

        // write to x0 is swallowed
        chk("t3_ready_before", 64'(lsu_ready), 64'd1);
        lsu_valid = 1'b1; lsu_addr = 5'd0; lsu_data = 32'h55;
        tick();
        lsu_valid = 1'b0;
        chk("t3_ready_after", 64'(lsu_ready), 64'd1);
        chk("t3_pending", 64'(pending), 64'd0);
        repeat (3) tick();
        chk("t3_we3", 64'(we3), 64'd0);
        chk("t3_pending_late", 64'(pending), 64'd0);

        // sustained contention: strict alternation, FIFOs fill to 2
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            q.push_back('{a: 5'(1 + i),  d: 32'h100 + 32'(i)});
            q.push_back('{a: 5'(11 + i), d: 32'h200 + 32'(i)});
        end
        ai = 0; li = 0; cyc = 0;
        seen_alu_full = 1'b0; seen_lsu_full = 1'b0;
        while ((ai < 4 || li < 4) && cyc < 40) begin
            alu_valid = (ai < 4); alu_addr = 5'(1 + ai);  alu_data = 32'h100 + 32'(ai);
            lsu_valid = (li < 4); lsu_addr = 5'(11 + li); lsu_data = 32'h200 + 32'(li);
            ar = alu_ready; lr = lsu_ready;
            if (!ar) seen_alu_full = 1'b1;
            if (!lr) seen_lsu_full = 1'b1;
            tick();
            if (alu_valid && ar) ai++;
            if (lsu_valid && lr) li++;
            cyc++;
        end
        alu_valid = 1'b0; lsu_valid = 1'b0;
        chk("t4_all_accepted", 64'((ai == 4) && (li == 4)), 64'd1);
        chk("t4_alu_backpressure", 64'(seen_alu_full), 64'd1);
        chk("t4_lsu_backpressure", 64'(seen_lsu_full), 64'd1);
        cyc = 0;
        while (q.size() != 0 && cyc < 20) begin
            tick();
            cyc++;
        end
        chk("t4_drained", 64'(q.size()), 64'd0);
        tick();

        // reset with queued writes drops them
        pulse_reset();
        alu_valid = 1'b1; alu_addr = 5'd20; alu_data = 32'h301;
        lsu_valid = 1'b1; lsu_addr = 5'd21; lsu_data = 32'h401;
        q.push_back('{a: 5'd20, d: 32'h301});
        tick();
        alu_addr = 5'd22; alu_data = 32'h302;
        lsu_addr = 5'd23; lsu_data = 32'h402;
        tick();
        alu_valid = 1'b0; lsu_valid = 1'b0;
        chk("t5_lsu_full", 64'(lsu_ready), 64'd0);
        chk("t5_pending_full", 64'(pending), 64'h00F0_0000);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_we3", 64'(we3), 64'd0);
        chk("t5_pending", 64'(pending), 64'd0);
        chk("t5_alu_ready", 64'(alu_ready), 64'd1);
        chk("t5_lsu_ready", 64'(lsu_ready), 64'd1);
        repeat (6) tick();
        chk("t5_no_stale", 64'(q.size()), 64'd0);
        chk("t5_pending_late", 64'(pending), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
